rc5_encryptor: RTL and testbench



---
 rtl/rc5_encryptor.sv | 156 +++++++++++++++
 tb/tb_rc5_encryptor.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_encryptor.sv
// rtl/rc5_encryptor.sv - RC5-W/R block cipher core fed from a synchronous S-table RAM
// Optional feature macro: RC5_DECRYPT_EN adds the iDecrypt port and the inverse round datapath.
module rc5_encryptor #(
   parameter int W = 32,
   parameter int R = 12,
   parameter int T = 2*R+2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iStart,
   input  logic [W-1:0]         iDataA,
   input  logic [W-1:0]         iDataB,
   output logic [$clog2(T)-1:0] oS_address,
   input  logic [W-1:0]         iS_sub_i,
   output logic [W-1:0]         oDataA,
   output logic [W-1:0]         oDataB,
   output logic                 oBusy,
   output logic                 oDone
`ifdef RC5_DECRYPT_EN
   ,
   input  logic                 iDecrypt
`endif
);

   localparam int LG = $clog2(W);
   localparam int KW = $clog2(T);
   localparam logic [KW-1:0] K_LAST = KW'(T-1);

   typedef enum logic [1:0] {IDLE, FETCH, APPLY, DONE} state_t;

   state_t         state;
   logic [KW-1:0]  k;
   logic [W-1:0]   regA;
   logic [W-1:0]   regB;
`ifdef RC5_DECRYPT_EN
   logic           decMode;
`endif

   logic           kOdd;
   logic           kLow;
   logic           kFinal;
   logic [KW-1:0]  kNext;
   logic [W-1:0]   own;
   logic [W-1:0]   other;
   logic [W-1:0]   rotIn;
   logic [LG-1:0]  rotAmt;
   logic [LG:0]    rotBack;
   logic [W-1:0]   rotOut;
   logic [W-1:0]   result;

   // Decode which half of the round the current key word updates
   always_comb begin
      kOdd  = k[0];
      kLow  = (k[KW-1:1] == '0);
      own   = kOdd ? regB : regA;
      other = kOdd ? regA : regB;
   end

   // Select operand and amount for the single shared left rotator
   always_comb begin
      rotIn  = own ^ other;
      rotAmt = other[LG-1:0];
`ifdef RC5_DECRYPT_EN
      if (decMode) begin
         rotIn  = own - iS_sub_i;
         // a right rotate by n is a left rotate by W-n
         rotAmt = LG'(0) - other[LG-1:0];
      end
`endif
   end

   // amount 0 shifts the wrapped half out completely, leaving rotIn unchanged
   assign rotBack = (LG+1)'(W) - {1'b0, rotAmt};
   assign rotOut  = (rotIn << rotAmt) | (rotIn >> rotBack);

   // Finish the half-round and pick the next key index and terminal index
   always_comb begin
      result = kLow ? (own + iS_sub_i) : (rotOut + iS_sub_i);
      kNext  = k + KW'(1);
      kFinal = (k == K_LAST);
`ifdef RC5_DECRYPT_EN
      if (decMode) begin
         result = kLow ? rotIn : (rotOut ^ other);
         kNext  = k - KW'(1);
         kFinal = (k == '0);
      end
`endif
   end

   // Sequence fetch/apply per key word and register every output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         k          <= '0;
         regA       <= '0;
         regB       <= '0;
         oS_address <= '0;
         oDataA     <= '0;
         oDataB     <= '0;
         oBusy      <= 1'b0;
         oDone      <= 1'b0;
`ifdef RC5_DECRYPT_EN
         decMode    <= 1'b0;
`endif
      end else begin
         oDone <= 1'b0;
         case (state)
            IDLE: begin
               if (iStart) begin
                  regA  <= iDataA;
                  regB  <= iDataB;
                  oBusy <= 1'b1;
                  state <= FETCH;
`ifdef RC5_DECRYPT_EN
                  decMode    <= iDecrypt;
                  k          <= iDecrypt ? K_LAST : '0;
                  oS_address <= iDecrypt ? K_LAST : '0;
`else
                  k          <= '0;
                  oS_address <= '0;
`endif
               end
            end
            FETCH: begin
               // RAM data for oS_address arrives one cycle later
               state <= APPLY;
            end
            APPLY: begin
               if (kOdd) begin
                  regB <= result;
               end else begin
                  regA <= result;
               end
               if (kFinal) begin
                  state <= DONE;
               end else begin
                  k          <= kNext;
                  oS_address <= kNext;
                  state      <= FETCH;
               end
            end
            DONE: begin
               oDataA <= regA;
               oDataB <= regB;
               oDone  <= 1'b1;
               oBusy  <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc5_encryptor.sv
// tb/tb_rc5_encryptor.sv - scoreboard bench for rc5_encryptor (W=32/R=12 instance and R=1 instance)
`timescale 1ns/1ps
module tb_rc5_encryptor;

   localparam int TM = 26;
   localparam int TS = 4;
   localparam logic [31:0]  KAT_A  = 32'hEEDBA521;
   localparam logic [31:0]  KAT_B  = 32'h6D8F4B15;
   localparam logic [31:0]  KAT2_A = 32'hAC13C0F7;
   localparam logic [31:0]  KAT2_B = 32'h52892B5B;
   localparam logic [127:0] KEY2   = 128'h91CEA910_01A55563_51B241BE_19465F91;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   nVec = 0;
   int   nBad = 0;

   always #5 clk = ~clk;

   // Edge counter used to time done pulses
   always @(posedge clk) cyc <= cyc + 1;

   logic        mStart, sStart;
   logic [31:0] mA, mB, sA, sB;
   logic [4:0]  mAddr;
   logic [1:0]  sAddr;
   logic [31:0] mRd, sRd;
   logic [31:0] mDataA, mDataB, sDataA, sDataB;
   logic        mBusy, mDone, sBusy, sDone;
`ifdef RC5_DECRYPT_EN
   logic        mDec;
   logic        sDec;
`endif
   logic [31:0] sramM [TM];
   logic [31:0] sramS [TS];

   exp_t qM[$];
   exp_t qS[$];
   int   addrSeq[$];
   logic prevDoneM = 1'b0;
   logic prevDoneS = 1'b0;

   rc5_encryptor #(.W(32), .R(12), .T(TM)) dut (
      .clk(clk), .rst(rst), .iStart(mStart), .iDataA(mA), .iDataB(mB),
      .oS_address(mAddr), .iS_sub_i(mRd), .oDataA(mDataA), .oDataB(mDataB),
      .oBusy(mBusy), .oDone(mDone)
`ifdef RC5_DECRYPT_EN
      , .iDecrypt(mDec)
`endif
   );

   rc5_encryptor #(.W(32), .R(1), .T(TS)) dutS (
      .clk(clk), .rst(rst), .iStart(sStart), .iDataA(sA), .iDataB(sB),
      .oS_address(sAddr), .iS_sub_i(sRd), .oDataA(sDataA), .oDataB(sDataB),
      .oBusy(sBusy), .oDone(sDone)
`ifdef RC5_DECRYPT_EN
      , .iDecrypt(sDec)
`endif
   );

   // Synchronous single-port S RAMs
   always @(posedge clk) mRd <= sramM[mAddr];
   always @(posedge clk) sRd <= sramS[sAddr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [31:0] n);
      logic [4:0] s;
      s = n[4:0];
      return (v << s) | (v >> (6'd32 - {1'b0, s}));
   endfunction

   // Standard RC5-32 key expansion of a 16-byte key into sramM
   task automatic loadKey(input logic [127:0] lw);
      logic [31:0] l [4];
      logic [31:0] x, y;
      int i, j;
      for (int n = 0; n < 4; n++) l[n] = lw[32*n +: 32];
      sramM[0] = 32'hB7E15163;
      for (int n = 1; n < TM; n++) sramM[n] = sramM[n-1] + 32'h9E3779B9;
      x = 0; y = 0; i = 0; j = 0;
      for (int n = 0; n < 3*TM; n++) begin
         x = rotl32(sramM[i] + x + y, 32'd3);
         sramM[i] = x;
         y = rotl32(l[j] + x + y, x + y);
         l[j] = y;
         i = (i + 1) % TM;
         j = (j + 1) % 4;
      end
   endtask

   task automatic issueMain(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ea, input logic [31:0] eb);
      exp_t e;
      @(negedge clk);
      mA = a; mB = b; mStart = 1'b1;
      e.a = ea; e.b = eb; e.due = cyc + 2*TM + 2;
      qM.push_back(e);
      @(negedge clk);
      mStart = 1'b0;
   endtask

   task automatic issueSmall(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ea, input logic [31:0] eb);
      exp_t e;
      @(negedge clk);
      sA = a; sB = b; sStart = 1'b1;
      e.a = ea; e.b = eb; e.due = cyc + 2*TS + 2;
      qS.push_back(e);
      @(negedge clk);
      sStart = 1'b0;
   endtask

   task automatic waitMain(input string tag);
      int n;
      logic busyOk;
      n = 0; busyOk = 1'b1;
      addrSeq.delete();
      do begin
         @(negedge clk);
         n++;
         if (!mDone) begin
            if (!mBusy) busyOk = 1'b0;
            if (addrSeq.size() == 0 || addrSeq[addrSeq.size()-1] != int'(mAddr))
               addrSeq.push_back(int'(mAddr));
         end
      end while (!mDone && n < 200);
      check({tag, "_done_seen"}, mDone, 1'b1);
      check({tag, "_busy_held"}, busyOk, 1'b1);
   endtask

   task automatic waitSmall(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sDone && n < 100);
      check({tag, "_done_seen"}, sDone, 1'b1);
   endtask

   task automatic checkAddrSeq(input string tag, input logic down);
      int bad = 0;
      for (int i = 0; i < addrSeq.size(); i++)
         if (addrSeq[i] != (down ? TM-1-i : i)) bad++;
      check({tag, "_len"}, addrSeq.size(), TM);
      check({tag, "_order"}, bad, 0);
   endtask

   // Scoreboard monitor for the R=12 instance
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mDone) begin
            check("main_done_width", prevDoneM, 1'b0);
            check("main_busy_at_done", mBusy, 1'b0);
            check("main_done_expected", qM.size() > 0, 1'b1);
            if (qM.size() > 0) begin
               e = qM.pop_front();
               check("main_dataA", mDataA, e.a);
               check("main_dataB", mDataB, e.b);
               check("main_latency", cyc, e.due);
            end
         end
         prevDoneM = mDone;
      end
   end

   // Scoreboard monitor for the R=1 instance
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sDone) begin
            check("small_done_width", prevDoneS, 1'b0);
            check("small_done_expected", qS.size() > 0, 1'b1);
            if (qS.size() > 0) begin
               e = qS.pop_front();
               check("small_dataA", sDataA, e.a);
               check("small_dataB", sDataB, e.b);
               check("small_latency", cyc, e.due);
            end
         end
         prevDoneS = sDone;
      end
   end

   // Time limit so a stuck design still ends the run
   initial begin
      #200000;
      $display("FAIL watchdog: got time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      exp_t e;
      int   n;
      logic stable, busyOk;

      mStart = 0; mA = 0; mB = 0; sStart = 0; sA = 0; sB = 0;
`ifdef RC5_DECRYPT_EN
      mDec = 0; sDec = 0;
`endif
      for (int i = 0; i < TM; i++) sramM[i] = '0;
      for (int i = 0; i < TS; i++) sramS[i] = '0;

      repeat (3) @(negedge clk);
      check("rst_addr", mAddr, 0);
      check("rst_dataA", mDataA, 0);
      check("rst_dataB", mDataB, 0);
      check("rst_busy", mBusy, 0);
      check("rst_done", mDone, 0);
      check("rst_small_busy", sBusy, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // zero S table, zero block
      issueMain(32'h0, 32'h0, 32'h0, 32'h0);
      waitMain("zero");
      checkAddrSeq("zero_addr_seq", 1'b0);

      // R=1 reference S={1,2,3,4}
      for (int i = 0; i < TS; i++) sramS[i] = 32'(i + 1);
      issueSmall(32'h0, 32'h0, 32'h0000000F, 32'h00068004);
      waitSmall("small_ref");
      // R=1 with zero S, rotations that wrap the top bit
      for (int i = 0; i < TS; i++) sramS[i] = '0;
      issueSmall(32'h80000000, 32'h00000001, 32'h00000003, 32'h00000010);
      waitSmall("small_rot");

      // known answers
      loadKey(128'h0);
      issueMain(32'h0, 32'h0, KAT_A, KAT_B);
      waitMain("kat0");
      loadKey(KEY2);
      issueMain(KAT_A, KAT_B, KAT2_A, KAT2_B);
      waitMain("kat2");

      // iStart held high through a run and past done
      loadKey(128'h0);
      @(negedge clk);
      mA = 0; mB = 0; mStart = 1'b1;
      e.a = KAT_A; e.b = KAT_B; e.due = cyc + 2*TM + 2;
      qM.push_back(e);
      e.due = e.due + 2*TM + 2;
      qM.push_back(e);
      waitMain("hold_first");
      @(negedge clk);
      check("hold_restart_busy", mBusy, 1'b1);
      mStart = 1'b0;
      stable = 1'b1; busyOk = 1'b1; n = 0;
      do begin
         if (mDataA !== KAT_A || mDataB !== KAT_B) stable = 1'b0;
         if (!mBusy) busyOk = 1'b0;
         @(negedge clk);
         n++;
      end while (!mDone && n < 200);
      check("hold_second_done_seen", mDone, 1'b1);
      check("hold_outputs_stable", stable, 1'b1);
      check("hold_second_busy", busyOk, 1'b1);

      // asynchronous reset while k=7
      @(negedge clk);
      mA = 0; mB = 0; mStart = 1'b1;
      @(negedge clk);
      mStart = 1'b0;
      n = 0;
      while (mAddr != 5'd7 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_reach_k7", mAddr, 7);
      #2 rst = 1'b0;
      #1;
      check("arst_addr", mAddr, 0);
      check("arst_dataA", mDataA, 0);
      check("arst_dataB", mDataB, 0);
      check("arst_busy", mBusy, 0);
      check("arst_done", mDone, 0);
      check("arst_small_dataA", sDataA, 0);
      @(negedge clk);
      rst = 1'b1;
      issueMain(32'h0, 32'h0, KAT_A, KAT_B);
      waitMain("post_rst");
      checkAddrSeq("post_rst_addr_seq", 1'b0);

`ifdef RC5_DECRYPT_EN
      // decryption of the known answers
      loadKey(128'h0);
      mDec = 1'b1;
      issueMain(KAT_A, KAT_B, 32'h0, 32'h0);
      waitMain("dec0");
      checkAddrSeq("dec0_addr_seq", 1'b1);
      loadKey(KEY2);
      issueMain(KAT2_A, KAT2_B, KAT_A, KAT_B);
      waitMain("dec2");
      mDec = 1'b0;
      sDec = 1'b1;
      for (int i = 0; i < TS; i++) sramS[i] = 32'(i + 1);
      issueSmall(32'h0000000F, 32'h00068004, 32'h0, 32'h0);
      waitSmall("small_dec");
      sDec = 1'b0;
`endif

      repeat (3) @(negedge clk);
      check("main_queue_drained", qM.size(), 0);
      check("small_queue_drained", qS.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
